age_issue_scheduler: RTL and testbench

- Small out-of-order issue scheduler. Holds up to ENTRIES instructions, each stamped with a wrap-around age tag; issues the oldest ready entry first.
- Tag age uses the team's modular rule: tag a is before tag b iff bit TAG_W-1 of (a - b) mod 2^TAG_W is 1.
- Sits between rename/dispatch and a single execution port. Supports wakeup by tag and flush of everything younger than a given tag.

---
 rtl/age_issue_scheduler.sv | 152 +++++++++++++++
 tb/tb_age_issue_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/age_issue_scheduler.sv
// Out-of-order issue scheduler: holds ENTRIES tagged instructions and issues the
// oldest ready one into a single output register, with tag wakeup and younger-flush.
module age_issue_scheduler #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_rdy_now,
  output logic              in_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wake_valid,
  input  logic [TAG_W-1:0]  wake_tag,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              out_accept
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] SPAN_LIMIT = TAG_W'((1 << (TAG_W - 1)) - 1);

  logic [ENTRIES-1:0] slot_valid;
  logic [ENTRIES-1:0] slot_rdy;
  logic [TAG_W-1:0]   slot_tag  [ENTRIES];
  logic [DATA_W-1:0]  slot_data [ENTRIES];
  logic [TAG_W-1:0]   next_tag;

  logic               live_any;
  logic [TAG_W-1:0]   oldest_tag;
  logic [TAG_W-1:0]   tag_span;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               cand_found;
  logic [IDX_W-1:0]   cand_idx;
  logic [TAG_W-1:0]   cand_tag;
  logic               do_load;
  logic               do_insert;

  // a is older than b when the modular difference has its top bit set
  function automatic logic is_before(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return diff[TAG_W-1];
  endfunction

  always_comb begin
    live_any   = out_valid;
    oldest_tag = out_tag;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_valid[i] && (!live_any || is_before(slot_tag[i], oldest_tag))) begin
        live_any   = 1'b1;
        oldest_tag = slot_tag[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!slot_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_tag   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_valid[i] && slot_rdy[i] && (!cand_found || is_before(slot_tag[i], cand_tag))) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
        cand_tag   = slot_tag[i];
      end
    end
  end

  // The span guard keeps every live tag inside half the tag space
  assign tag_span  = next_tag - oldest_tag;
  assign in_ready  = rst_n && !flush_valid && free_found &&
                     (!live_any || (tag_span < SPAN_LIMIT));
  assign alloc_tag = next_tag;
  assign do_insert = in_valid && in_ready;
  assign do_load   = (!out_valid || out_accept) && cand_found && !flush_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_rdy   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        // Flush kills first so a simultaneous wake only reaches survivors
        if (flush_valid && slot_valid[i] && is_before(flush_tag, slot_tag[i])) begin
          slot_valid[i] <= 1'b0;
        end else begin
          if (do_load && (cand_idx == IDX_W'(i))) begin
            slot_valid[i] <= 1'b0;
          end
          if (wake_valid && slot_valid[i] && (slot_tag[i] == wake_tag)) begin
            slot_rdy[i] <= 1'b1;
          end
        end
        if (do_insert && (free_idx == IDX_W'(i))) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= next_tag;
          slot_data[i]  <= in_data;
          slot_rdy[i]   <= in_rdy_now || (wake_valid && (wake_tag == next_tag));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush_valid && out_valid && is_before(flush_tag, out_tag)) begin
      out_valid <= 1'b0;
    end else if (do_load) begin
      out_valid <= 1'b1;
      out_data  <= slot_data[cand_idx];
      out_tag   <= cand_tag;
    end else if (out_accept) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_tag <= '0;
    end else if (flush_valid) begin
      next_tag <= flush_tag + TAG_W'(1);
    end else if (do_insert) begin
      next_tag <= next_tag + TAG_W'(1);
    end
  end

endmodule

// File: tb/tb_age_issue_scheduler.sv
// Scoreboard bench for age_issue_scheduler: directed scenarios push the expected
// issue order into a queue and an independent monitor checks each accepted output.
module tb_age_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_rdy_now;
  logic        in_ready;
  logic [7:0]  alloc_tag;
  logic        wake_valid;
  logic [7:0]  wake_tag;
  logic        flush_valid;
  logic [7:0]  flush_tag;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_tag;
  logic        out_accept;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  age_issue_scheduler #(.ENTRIES(4), .TAG_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_rdy_now(in_rdy_now),
    .in_ready(in_ready), .alloc_tag(alloc_tag),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_accept(out_accept)
  );

  always #5 clk = ~clk;

  function automatic void check_output(input string name, input int unsigned act, input int unsigned exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void expect_issue(input logic [15:0] d, input logic [7:0] t);
    exp_t e;
    e.data = d;
    e.tag  = t;
    sb.push_back(e);
  endfunction

  // Monitor: every cycle the port takes the output is one issued entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_accept) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_issue: got tag %0h data %0h expected none", out_tag, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("issue_tag", out_tag, e.tag);
        check_output("issue_data", out_data, e.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      wake_valid  = 1'b0;
      flush_valid = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic rdy);
    in_valid   = 1'b1;
    in_data    = d;
    in_rdy_now = rdy;
    tick();
  endtask

  task automatic do_wake(input logic [7:0] t);
    wake_valid = 1'b1;
    wake_tag   = t;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Back-to-back ready entries that issue straight through (out_accept must be 1)
  task automatic stream(input int n, input logic [15:0] base, input logic [7:0] first_tag);
    for (int i = 0; i < n; i++) begin
      expect_issue(base + 16'(i), first_tag + 8'(i));
      apply_stimulus(base + 16'(i), 1'b1);
    end
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rdy_now = 1'b0;
    wake_valid = 1'b0; wake_tag = '0; flush_valid = 1'b0; flush_tag = '0;
    out_accept = 1'b0;

    // Reset values and single-entry latency
    tick(2);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_tag", out_tag, 0);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_alloc_tag", alloc_tag, 0);
    rst_n = 1'b1;
    #1;
    check_output("post_rst_in_ready", in_ready, 1);
    expect_issue(16'hA000, 8'd0);
    apply_stimulus(16'hA000, 1'b1);
    check_output("lat_edge1_out_valid", out_valid, 0);
    check_output("lat_alloc_tag", alloc_tag, 1);
    tick();
    check_output("lat_edge2_out_valid", out_valid, 1);
    check_output("lat_edge2_out_tag", out_tag, 0);
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    check_output("lat_edge3_out_valid", out_valid, 0);

    // Wakeup order: only the woken entry can issue
    do_reset();
    out_accept = 1'b1;
    apply_stimulus(16'h2000, 1'b0);
    apply_stimulus(16'h2001, 1'b0);
    apply_stimulus(16'h2002, 1'b0);
    expect_issue(16'h2002, 8'd2);
    expect_issue(16'h2000, 8'd0);
    do_wake(8'd2);
    do_wake(8'd0);
    tick(3);
    expect_issue(16'h2001, 8'd1);
    do_wake(8'd1);
    tick(3);
    check_output("wake_drained", out_valid, 0);

    // Backpressure: output holds, slots fill, one accept frees a slot
    do_reset();
    out_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_issue(16'h3000 + 16'(i), 8'(i));
      apply_stimulus(16'h3000 + 16'(i), 1'b1);
    end
    check_output("bp_full_in_ready", in_ready, 0);
    check_output("bp_out_tag", out_tag, 0);
    tick(2);
    check_output("bp_stable_out_tag", out_tag, 0);
    check_output("bp_stable_out_data", out_data, 16'h3000);
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    check_output("bp_after_accept_in_ready", in_ready, 1);
    check_output("bp_after_accept_out_tag", out_tag, 1);
    out_accept = 1'b1;
    tick(6);

    // Wrap-around: oldest-first across the 255->0 boundary
    do_reset();
    out_accept = 1'b1;
    stream(254, 16'h0000, 8'd0);
    check_output("wrap_alloc_tag", alloc_tag, 254);
    out_accept = 1'b0;
    apply_stimulus(16'hB0FE, 1'b0);
    apply_stimulus(16'hB0FF, 1'b0);
    apply_stimulus(16'hB000, 1'b0);
    apply_stimulus(16'hB001, 1'b0);
    check_output("wrap_full_in_ready", in_ready, 0);
    check_output("wrap_alloc_after", alloc_tag, 2);
    expect_issue(16'hB0FE, 8'd254);
    expect_issue(16'hB0FF, 8'd255);
    expect_issue(16'hB000, 8'd0);
    expect_issue(16'hB001, 8'd1);
    do_wake(8'd254);
    do_wake(8'd1);
    do_wake(8'd0);
    do_wake(8'd255);
    tick();
    check_output("wrap_held_out_tag", out_tag, 254);
    out_accept = 1'b1;
    tick(6);

    // Flush of everything younger than 11, with a wake to a killed tag
    do_reset();
    out_accept = 1'b1;
    stream(10, 16'h4000, 8'd0);
    out_accept = 1'b0;
    apply_stimulus(16'h400A, 1'b1);
    apply_stimulus(16'h400B, 1'b0);
    apply_stimulus(16'h400C, 1'b0);
    apply_stimulus(16'h400D, 1'b0);
    check_output("fl_pre_out_tag", out_tag, 10);
    flush_valid = 1'b1; flush_tag = 8'd11;
    wake_valid = 1'b1; wake_tag = 8'd12;
    in_valid = 1'b1; in_data = 16'hDEAD; in_rdy_now = 1'b1;
    #1;
    check_output("fl_in_ready", in_ready, 0);
    tick();
    check_output("fl_alloc_tag", alloc_tag, 12);
    check_output("fl_out_valid", out_valid, 1);
    check_output("fl_out_tag", out_tag, 10);
    expect_issue(16'h400A, 8'd10);
    expect_issue(16'h400B, 8'd11);
    do_wake(8'd13);
    do_wake(8'd11);
    out_accept = 1'b1;
    tick(5);
    check_output("fl_drained", out_valid, 0);

    // Tag-span guard: an unwoken oldest entry eventually blocks dispatch
    do_reset();
    out_accept = 1'b1;
    stream(5, 16'h5000, 8'd0);
    apply_stimulus(16'h5005, 1'b0);
    for (int i = 0; i < 126; i++) begin
      if (i == 125) check_output("span_126_in_ready", in_ready, 1);
      expect_issue(16'h6000 + 16'(i), 8'(6 + i));
      apply_stimulus(16'h6000 + 16'(i), 1'b1);
    end
    tick(2);
    check_output("span_127_in_ready", in_ready, 0);
    check_output("span_alloc_tag", alloc_tag, 132);
    apply_stimulus(16'hBAD0, 1'b1);
    check_output("span_blocked_alloc", alloc_tag, 132);
    expect_issue(16'h5005, 8'd5);
    do_wake(8'd5);
    tick(3);
    check_output("span_recovered_in_ready", in_ready, 1);

    // Asynchronous reset mid-operation leaves nothing to issue
    do_reset();
    out_accept = 1'b0;
    apply_stimulus(16'h7000, 1'b1);
    apply_stimulus(16'h7001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_out_valid", out_valid, 0);
    check_output("async_rst_in_ready", in_ready, 0);
    check_output("async_rst_alloc_tag", alloc_tag, 0);
    tick();
    rst_n = 1'b1;
    out_accept = 1'b1;
    do_wake(8'd1);
    do_wake(8'd0);
    tick(4);
    check_output("async_rst_no_issue", out_valid, 0);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
